// File: rtl/date_entry_ctrl.sv
// date_entry_ctrl: button debouncing, show/edit-month/edit-day FSM and the
// month/day date registers. Feeds BCD digits and a blanking mask to display.
// Optional build macro: DATE_BLINK_EN (blinks the field being edited).
module date_entry_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned BLINK_TICKS     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode_n,
  input  logic       btn_inc_n,
  input  logic       sw_run,
  input  logic       tick,
  output logic [3:0] month,
  output logic [4:0] day,
  output logic [3:0] day_tens,
  output logic [3:0] day_ones,
  output logic [1:0] state,
  output logic [1:0] blank_mask
);

  typedef enum logic [1:0] {
    SHOW      = 2'b00,
    EDIT_MON  = 2'b01,
    EDIT_DAY  = 2'b10,
    ST_UNUSED = 2'b11
  } state_e;

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES == 0 || BLINK_TICKS == 0) begin : g_bad_params
    $error("date_entry_ctrl: DEBOUNCE_CYCLES and BLINK_TICKS must be >= 1");
  end

  // Index 0 = mode button, index 1 = increment button; all levels active-low.
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       db_q, db_d;
  logic [1:0]       press_q, press_d;
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];

  logic       mode_p, inc_p;
  state_e     state_q, state_d;
  logic [3:0] month_q, month_d;
  logic [4:0] day_q, day_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;

  function automatic logic [4:0] dim_f(input logic [3:0] m);
    case (m)
      4'd2:                      dim_f = 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   dim_f = 5'd30;
      default:                   dim_f = 5'd31;
    endcase
  endfunction

  // Synchronizers, debounced levels, counters and press pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      db_q    <= '1;
      press_q <= '0;
      for (int unsigned i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= {btn_inc_n, btn_mode_n};
      sync2_q <= sync1_q;
      db_q    <= db_d;
      press_q <= press_d;
      for (int unsigned i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Accept a new level after DEBOUNCE_CYCLES consecutive differing samples; pulse on press.
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      db_d[i]    = db_q[i];
      press_d[i] = 1'b0;
      cnt_d[i]   = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i]    = sync2_q[i];
          press_d[i] = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign mode_p = press_q[0];
  assign inc_p  = press_q[1];

  // Edit FSM next state: mode press cycles SHOW -> EDIT_MON -> EDIT_DAY -> SHOW.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SHOW:     if (mode_p) state_d = EDIT_MON;
      EDIT_MON: if (mode_p) state_d = EDIT_DAY;
      EDIT_DAY: if (mode_p) state_d = SHOW;
      default:  state_d = SHOW;
    endcase
  end

  // Date next value: run-mode tick advance, or field increment in edit states.
  always_comb begin
    month_d = month_q;
    day_d   = day_q;
    if (state_q == SHOW && tick && sw_run) begin
      if (day_q >= dim_f(month_q)) begin
        day_d   = 5'd1;
        month_d = (month_q >= 4'd12) ? 4'd1 : month_q + 4'd1;
      end else begin
        day_d = day_q + 5'd1;
      end
    end else if (inc_p && !mode_p) begin
      if (state_q == EDIT_MON) begin
        month_d = (month_q >= 4'd12) ? 4'd1 : month_q + 4'd1;
        if (day_q > dim_f(month_d)) day_d = dim_f(month_d);
      end else if (state_q == EDIT_DAY) begin
        day_d = (day_q >= dim_f(month_q)) ? 5'd1 : day_q + 5'd1;
      end
    end
  end

  // BCD split of the next day so the digits land on the same edge as day.
  always_comb begin
    tens_d = 4'd0;
    ones_d = day_d[3:0];
    if (day_d >= 5'd30) begin
      tens_d = 4'd3;
      ones_d = 4'(day_d - 5'd30);
    end else if (day_d >= 5'd20) begin
      tens_d = 4'd2;
      ones_d = 4'(day_d - 5'd20);
    end else if (day_d >= 5'd10) begin
      tens_d = 4'd1;
      ones_d = 4'(day_d - 5'd10);
    end
  end

  // State and date registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SHOW;
      month_q <= 4'd1;
      day_q   <= 5'd1;
      tens_q  <= 4'd0;
      ones_q  <= 4'd1;
    end else begin
      state_q <= state_d;
      month_q <= month_d;
      day_q   <= day_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
    end
  end

  assign month    = month_q;
  assign day      = day_q;
  assign day_tens = tens_q;
  assign day_ones = ones_q;
  assign state    = state_q;

`ifdef DATE_BLINK_EN
  localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blank_q, blank_d;

  // Blink phase: restart visible on any state change or inc press, else count edit ticks.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blank_d     = blank_q;
    if (state_d != state_q || inc_p) begin
      blink_cnt_d = '0;
      blank_d     = 1'b0;
    end else if (state_q != SHOW && tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blank_d     = ~blank_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Blink counter and phase registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blank_q     <= blank_d;
    end
  end

  // Route the blink phase to whichever field is under edit.
  always_comb begin
    blank_mask = '0;
    case (state_q)
      EDIT_MON: blank_mask = {1'b0, blank_q};
      EDIT_DAY: blank_mask = {blank_q, 1'b0};
      default:  blank_mask = '0;
    endcase
  end
`else
  assign blank_mask = '0;
`endif

endmodule

// File: tb/tb_date_entry_ctrl.sv
// Scoreboard bench for date_entry_ctrl: stimulus pushes expected snapshots
// from a calendar-level model; a monitor pops and compares on falling edges.
module tb_date_entry_ctrl;

  localparam int unsigned DEB = 4;
  localparam int unsigned BLK = 2;

  logic       clk = 1'b0;
  logic       rst, btn_mode_n, btn_inc_n, sw_run, tick;
  logic [3:0] month, day_tens, day_ones;
  logic [4:0] day;
  logic [1:0] state, blank_mask;

  always #5 clk = ~clk;

  date_entry_ctrl #(.DEBOUNCE_CYCLES(DEB), .BLINK_TICKS(BLK)) dut (
    .clk(clk), .rst(rst), .btn_mode_n(btn_mode_n), .btn_inc_n(btn_inc_n),
    .sw_run(sw_run), .tick(tick), .month(month), .day(day),
    .day_tens(day_tens), .day_ones(day_ones), .state(state), .blank_mask(blank_mask)
  );

  typedef struct packed {
    logic [1:0] st;
    logic [3:0] mon;
    logic [4:0] dy;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [1:0] blank;
  } snap_t;

  snap_t exp_q[$];
  string name_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Calendar model: edit mode index 0/1/2, month, day, ticks seen in current edit visit.
  int m_st, m_mon, m_day, m_bcnt;
  int dim_tab[13] = '{0, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

  function automatic int day_of_year(int mon, int d);
    int s = d;
    for (int k = 1; k < mon; k++) s += dim_tab[k];
    return s;
  endfunction

  function void m_reset();
    m_st = 0; m_mon = 1; m_day = 1; m_bcnt = 0;
  endfunction

  function void m_tick(bit run);
    int doy;
    if (m_st == 0) begin
      if (run) begin
        doy = day_of_year(m_mon, m_day) % 365;
        m_mon = 1;
        while (doy >= dim_tab[m_mon]) begin
          doy -= dim_tab[m_mon];
          m_mon++;
        end
        m_day = doy + 1;
      end
    end else begin
      m_bcnt++;
    end
  endfunction

  function void m_mode();
    m_st = (m_st + 1) % 3;
    m_bcnt = 0;
  endfunction

  function void m_inc();
    if (m_st == 1) begin
      m_mon = (m_mon % 12) + 1;
      if (m_day > dim_tab[m_mon]) m_day = dim_tab[m_mon];
    end else if (m_st == 2) begin
      m_day = (m_day % dim_tab[m_mon]) + 1;
    end
    m_bcnt = 0;
  endfunction

  function automatic snap_t m_snap();
    snap_t s;
    logic  b;
    s.st   = 2'(m_st);
    s.mon  = 4'(m_mon);
    s.dy   = 5'(m_day);
    s.tens = 4'(m_day / 10);
    s.ones = 4'(m_day % 10);
    s.blank = 2'b00;
`ifdef DATE_BLINK_EN
    b = 1'((m_bcnt / BLK) % 2);
    if (m_st == 1) s.blank = {1'b0, b};
    else if (m_st == 2) s.blank = {b, 1'b0};
`else
    b = 1'b0;
    s.blank = {b, b};
`endif
    return s;
  endfunction

  // Monitor: compare one expected snapshot per falling edge while any are queued.
  initial begin
    snap_t e, a;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = '{state, month, day, day_tens, day_ones, blank_mask};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL %s: got st=%b m=%0d d=%0d bcd=%0d%0d bm=%b, want st=%b m=%0d d=%0d bcd=%0d%0d bm=%b",
                   nm, a.st, a.mon, a.dy, a.tens, a.ones, a.blank,
                   e.st, e.mon, e.dy, e.tens, e.ones, e.blank);
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_now(string nm);
    exp_q.push_back(m_snap());
    name_q.push_back(nm);
  endtask

  task automatic check(string nm);
    expect_now(nm);
    cyc(1);
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    m_tick(sw_run);
  endtask

  task automatic raw_press(bit pm, bit pi, int hold);
    btn_mode_n = ~pm;
    btn_inc_n  = ~pi;
    cyc(hold);
    btn_mode_n = 1'b1;
    btn_inc_n  = 1'b1;
    cyc(DEB + 6);
  endtask

  task automatic press_btn(bit pm, bit pi);
    raw_press(pm, pi, $urandom_range(DEB + 1, DEB + 5));
    if (pm) m_mode();
    else if (pi) m_inc();
  endtask

  task automatic goto_date(int mon, int d);
    press_btn(1, 0);
    while (m_mon != mon) press_btn(0, 1);
    press_btn(1, 0);
    while (m_day != d) press_btn(0, 1);
    press_btn(1, 0);
  endtask

  initial begin
    int op, wait_cnt;
    rst = 1'b1; btn_mode_n = 1'b1; btn_inc_n = 1'b1; sw_run = 1'b0; tick = 1'b0;
    m_reset();
    cyc(3);
    check("reset_held");
    rst = 1'b0;
    cyc(2);
    check("reset_released");

    // Run mode: month rollover, year rollover, frozen when sw_run=0.
    sw_run = 1'b1;
    repeat (30) do_tick();
    check("tick_to_jan31");
    do_tick();
    check("tick_to_feb1");
    sw_run = 1'b0;
    goto_date(12, 31);
    check("preset_dec31");
    sw_run = 1'b1;
    do_tick();
    check("year_wrap");
    sw_run = 1'b0;
    repeat (5) do_tick();
    check("run_off_frozen");

    // Month edit with day clamp.
    goto_date(1, 31);
    press_btn(1, 0);
    check("enter_edit_mon");
    press_btn(0, 1);
    check("feb_clamp");
    repeat (11) press_btn(0, 1);
    check("month_wrap");

    // Day edit wrap at 30-day month, then back to SHOW where inc is ignored.
    while (m_mon != 4) press_btn(0, 1);
    press_btn(1, 0);
    while (m_day != 30) press_btn(0, 1);
    check("apr30");
    press_btn(0, 1);
    check("day_wrap");
    press_btn(1, 0);
    check("back_show");
    press_btn(0, 1);
    check("inc_in_show");

    // Debounce boundary and mode-over-inc priority.
    press_btn(1, 0);
    raw_press(0, 1, DEB - 1);
    check("short_press");
    press_btn(1, 0);
    press_btn(1, 0);
    press_btn(1, 1);
    check("mode_beats_inc");
    press_btn(1, 0);
    press_btn(1, 0);

    // Press pulse coincident with a run tick: both take effect; latency is 2+DEB.
    sw_run = 1'b1;
    btn_mode_n = 1'b0;
    cyc(DEB + 2);
    expect_now("press_latency");
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    m_tick(1'b1);
    m_mode();
    expect_now("press_and_tick");
    cyc(1);
    btn_mode_n = 1'b1;
    cyc(DEB + 6);
    press_btn(1, 0);
    press_btn(1, 0);
    sw_run = 1'b0;

    // Asynchronous reset in the middle of a day edit.
    press_btn(1, 0);
    while (m_mon != 7) press_btn(0, 1);
    press_btn(1, 0);
    while (m_day != 15) press_btn(0, 1);
    check("jul15_edit_day");
    rst = 1'b1;
    m_reset();
    #1;
    check("reset_mid_edit");
    rst = 1'b0;
    cyc(2);

    // Blink phase in month edit (always-visible when the feature is built out).
    press_btn(1, 0);
    repeat (2) do_tick();
    check("blink_2_ticks");
    repeat (2) do_tick();
    check("blink_4_ticks");
    press_btn(1, 0);
    press_btn(1, 0);

    // Randomized operations against the calendar model.
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: begin
          sw_run = 1'($urandom_range(0, 1));
          repeat ($urandom_range(1, 3)) do_tick();
        end
        1: press_btn(1, 0);
        2: press_btn(0, 1);
        default: raw_press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           $urandom_range(1, DEB - 1));
      endcase
      check("random_op");
    end

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      cyc(1);
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      $display("FAIL drain: got %0d unchecked snapshots, want 0", exp_q.size());
      n_bad += exp_q.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
